// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam logic [12:0] BAUD_DIV_9600 = 13'd5208;
  localparam int          CLK_FREQ_HZ   = 50_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits, LSB first, one stop bit sampled mid-bit.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits.
module uart_rx
  import uart_pkg::*;
#(
  parameter logic [12:0] BAUD_DIV = BAUD_DIV_9600
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy_flag
);

  localparam logic [12:0] HALF = BAUD_DIV >> 1;
  localparam logic [12:0] LAST = BAUD_DIV - 13'd1;

  logic        rx_s;
  uart_state_e state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        rx_prev_q;
  logic        rx_valid_q, rx_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        busy_q, busy_d;
  logic        par_mismatch;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .d       (rx),
    .q       (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bit_q, par_bit_d;
  logic parity_err_q, parity_err_d;

  // Even parity: data plus parity bit must hold an even number of ones.
  assign par_mismatch = ^{shift_q, par_bit_q};
  assign parity_err   = parity_err_q;
`else
  assign par_mismatch = 1'b0;
  assign parity_err   = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    rx_valid_d   = 1'b0;
    frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d    = par_bit_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s) state_d = START;
      end
      START: begin
        // A start bit that is high again at mid-bit was a glitch.
        if (cnt_q == HALF) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == LAST) begin
          cnt_d     = '0;
          par_bit_d = rx_s;
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end
`endif
      STOP: begin
        // Return to IDLE mid stop bit so a back-to-back start edge is caught.
        if (cnt_q == LAST) begin
          cnt_d       = '0;
          state_d     = IDLE;
          frame_err_d = !rx_s;
          if (rx_s && !par_mismatch) begin
            data_out_d = shift_q;
            rx_valid_d = 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          parity_err_d = par_mismatch;
`endif
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      data_out_q   <= 8'h00;
      rx_prev_q    <= 1'b1;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      rx_prev_q    <= rx_s;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign data_out  = data_out_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy_flag = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at BAUD_DIV = 16; honours UART_RX_PARITY_EN.
module tb_uart_rx;

  localparam int BD = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 10;
`else
  localparam int NBITS = 9;
`endif
  localparam int LAT_NOM = 2 + BD / 2 + NBITS * BD + 1;

  logic       sys_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       rx      = 1'b1;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy_flag;

  uart_rx #(.BAUD_DIV(13'd16)) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data_out   (data_out),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy_flag  (busy_flag)
  );

  always #5 sys_clk = ~sys_clk;

  // kind = {parity_err, frame_err, rx_valid} expected at the pulse
  typedef struct packed {
    logic [2:0] kind;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         fall_cyc = 0;
  bit         lat_armed = 1'b0;
  logic [7:0] model_last = 8'h00;
  logic [2:0] pulse_prev = 3'b000;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumer: every output pulse must match the next expectation.
  always @(negedge sys_clk) begin
    logic [2:0] pulses;
    exp_t       e;
    int         lat;
    pulses = {parity_err, frame_err, rx_valid};
    if (rst_n && pulses != 3'b000) begin
      check_eq("pulse_one_cycle", {29'd0, pulses & pulse_prev}, 32'd0);
      if (sb.size() == 0) begin
        check_eq("unexpected_pulse", {29'd0, pulses}, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("pulse_kind", {29'd0, pulses}, {29'd0, e.kind});
        check_eq("data_out", {24'd0, data_out}, {24'd0, e.data});
        if (lat_armed && rx_valid) begin
          lat = cyc - fall_cyc;
          lat_armed = 1'b0;
          check_eq("latency_in_range", {31'd0, (lat >= LAT_NOM - 1) && (lat <= LAT_NOM + 1)}, 32'd1);
        end
      end
    end
    pulse_prev = pulses;
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BD) @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input bit arm_lat);
    logic perr;
    exp_t e;
    perr = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr = ^{d, par};
`endif
    if (!stop)     e.kind = {perr, 2'b10};
    else if (perr) e.kind = 3'b100;
    else begin
      e.kind     = 3'b001;
      model_last = d;
    end
    e.data = model_last;
    sb.push_back(e);
    fall_cyc  = cyc + 1;
    lat_armed = arm_lat;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`endif
    send_bit(stop);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (4) @(posedge sys_clk);
    #1;
    check_eq("rst_data_out", {24'd0, data_out}, 32'd0);
    check_eq("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check_eq("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check_eq("rst_parity_err", {31'd0, parity_err}, 32'd0);
    check_eq("rst_busy", {31'd0, busy_flag}, 32'd0);
    rst_n = 1'b1;
    idle(2 * BD);

    // Clean 0x55 frame, latency measured
    send_frame(8'h55, 1'b0, 1'b1, 1'b1);
    idle(2 * BD);

    // Short low glitch: must be rejected without any pulse
    rx = 1'b0;
    repeat (5) @(posedge sys_clk);
    #1;
    rx = 1'b1;
    check_eq("glitch_busy_high", {31'd0, busy_flag}, 32'd1);
    repeat (7) @(posedge sys_clk);
    #1;
    check_eq("glitch_busy_cleared", {31'd0, busy_flag}, 32'd0);
    idle(2 * BD);

    // Framing error keeps previous byte
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    idle(2 * BD);

    // Back-to-back frames, no idle gap
    send_frame(8'hA5, ^8'hA5, 1'b1, 1'b0);
    send_frame(8'h3C, ^8'h3C, 1'b1, 1'b0);
    idle(2 * BD);

    // Reset asserted during bit 4 of 0xFF
    @(posedge sys_clk);
    #1;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (8) @(posedge sys_clk);
    #1;
    check_eq("midframe_busy", {31'd0, busy_flag}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_busy", {31'd0, busy_flag}, 32'd0);
    check_eq("async_rst_data_out", {24'd0, data_out}, 32'd0);
    repeat (3) @(posedge sys_clk);
    #1;
    rst_n      = 1'b1;
    model_last = 8'h00;
    idle(2 * BD);
    send_frame(8'h12, ^8'h12, 1'b1, 1'b0);
    idle(2 * BD);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b0, 1'b1, 1'b0);
    idle(2 * BD);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    idle(2 * BD);
    send_frame(8'h07, 1'b0, 1'b0, 1'b0);
    idle(2 * BD);
`endif

    idle(3 * BD);
    check_eq("scoreboard_drained", sb.size(), 32'd0);
    check_eq("final_idle", {31'd0, busy_flag}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 13'd5208, sys_clk cycles per bit (50 MHz, 9600 baud).
REQ-002 SHALL have port sys_clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rx  input  1  serial line, asynchronous to sys_clk, idle high.
REQ-005 SHALL have port data_out  output  8  last correctly framed byte received.
REQ-006 SHALL have port rx_valid  output  1  one-cycle pulse, data_out updated this cycle.
REQ-007 SHALL have port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-008 SHALL have port parity_err  output  1  one-cycle pulse, parity mismatch (see REQ-024).
REQ-009 SHALL have port busy_flag  output  1  high whenever state is not IDLE.

Function
REQ-010 SHALL pass rx through a two-flop synchroniser before any use; rx_s is the second-flop output.
REQ-011 SHALL implement states IDLE, START, DATA, PARITY, STOP; 13-bit baud counter, 3-bit bit index, 8-bit shift register.
REQ-012 IDLE: on rx_s falling edge (previous rx_s 1, current 0) SHALL enter START with baud counter 0.
REQ-013 START: at counter == BAUD_DIV/2 SHALL sample rx_s; 0 -> DATA with counter 0; 1 -> IDLE (glitch rejected, no pulse).
REQ-014 DATA: counter runs 0..BAUD_DIV-1 and wraps; at BAUD_DIV-1 SHALL sample rx_s into shift register, LSB first.
REQ-015 After the 8th data sample SHALL enter PARITY if enabled, else STOP.
REQ-016 STOP: at counter == BAUD_DIV-1 SHALL sample rx_s and return to IDLE in the same cycle (mid stop bit).
REQ-017 Stop sample 1: data_out <= shift register and rx_valid high for exactly one cycle.
REQ-018 Stop sample 0: frame_err high one cycle; data_out unchanged; rx_valid stays low.
REQ-019 Parity error and frame error in one frame: both pulses in the same cycle, data_out unchanged.
REQ-020 Falling edge in the IDLE cycle directly after STOP SHALL be accepted (back-to-back frames, no idle gap needed).
REQ-021 rx_valid, frame_err, parity_err SHALL never be high for more than one consecutive cycle; rx_valid and frame_err mutually exclusive.
REQ-022 Latency: rx_valid asserts 2 + BAUD_DIV/2 + (9 or 10)*BAUD_DIV + 1 cycles after rx falls at the pin (±1).

Reset
REQ-023 rst_n low SHALL force IDLE, counters 0, synchroniser flops 1, data_out 8'h00, all pulses 0, busy_flag 0, at any time including mid-frame; next frame after release received normally.

Configuration
REQ-024 Macro UART_RX_PARITY_EN defined: PARITY state samples a 9th bit at BAUD_DIV-1; even parity over data+parity bit; mismatch -> parity_err pulse at stop sample, data_out not updated, rx_valid low.
REQ-025 Macro undefined: PARITY state unreachable/removed, frame is 10 bits, parity_err tied 0.

Structure
REQ-026 Shared package uart_pkg SHALL hold the state enum typedef, BAUD_DIV_9600 = 5208 and CLK_FREQ_HZ = 50_000_000.
REQ-027 Synchroniser SHALL be sub-module sync_2ff (1-bit, reset value parameterised, here 1).

Verification (BAUD_DIV = 16 in sim unless stated)
REQ-028 Send 8'h55, 8N1 -> exactly one rx_valid, data_out 8'h55, frame_err 0.
REQ-029 rx low for 5 cycles then high -> no pulse, busy_flag back to 0 by cycle 12.
REQ-030 Send 8'hA5 with stop bit 0 -> frame_err one cycle, data_out holds previous 8'h55.
REQ-031 Send 8'hA5 then 8'h3C with zero idle bits -> two rx_valid pulses, values 8'hA5 then 8'h3C.
REQ-032 Assert rst_n low at bit 4 of 8'hFF, release, send 8'h12 -> data_out 8'h00 after reset, then 8'h12 with one rx_valid.
REQ-033 With UART_RX_PARITY_EN, send 8'h07 with parity bit 0 -> parity_err pulse, no rx_valid; parity bit 1 -> rx_valid, data_out 8'h07.
